// File: rtl/universal_register_if.sv
`default_nettype none
// ============================================================================
// Module      : universal_register_if
// Description : Control, data and status bundle for universal_register.
//               The master side drives the operation request and the slave
//               side returns the registered value and flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface universal_register_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             co;
  logic             zero;

  modport master (
    output en, op, d, sin,
    input  q, co, zero
  );

  modport slave (
    input  en, op, d, sin,
    output q, co, zero
  );
endinterface
`default_nettype wire

// File: rtl/universal_register.sv
`default_nettype none
// ============================================================================
// Module      : universal_register
// Description : WIDTH-bit datapath register with hold, load, 1-bit logical
//               and arithmetic shifts, rotates and increment. The shift-out
//               or carry bit and a zero flag are registered alongside q.
// Revision    : 1.0 - initial release
// ============================================================================
module universal_register #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  wire logic           clk,
  input  wire logic           reset,
  universal_register_if.slave bus
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_INC  = 3'b111;

  localparam logic [WIDTH:0] INC_ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_reg;
  logic             co_reg;
  logic             zero_reg;

  logic [WIDTH-1:0] q_next;
  logic             co_next;
  logic [WIDTH:0]   inc_sum;

  // Incrementer is one bit wider than q so the wrap carry falls out naturally.
  assign inc_sum = {1'b0, q_reg} + INC_ONE;

  // Next-state selection; any unrecognised op (including X) holds.
  always_comb begin
    q_next  = q_reg;
    co_next = co_reg;
    case (bus.op)
      OP_HOLD: begin
        q_next  = q_reg;
        co_next = co_reg;
      end
      OP_LOAD: begin
        q_next  = bus.d;
        co_next = 1'b0;
      end
      OP_SHL: begin
        q_next  = {q_reg[WIDTH-2:0], bus.sin};
        co_next = q_reg[WIDTH-1];
      end
      OP_SHR: begin
        q_next  = {bus.sin, q_reg[WIDTH-1:1]};
        co_next = q_reg[0];
      end
      OP_ASR: begin
        q_next  = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
        co_next = q_reg[0];
      end
      OP_ROL: begin
        q_next  = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        co_next = q_reg[WIDTH-1];
      end
      OP_ROR: begin
        q_next  = {q_reg[0], q_reg[WIDTH-1:1]};
        co_next = q_reg[0];
      end
      OP_INC: begin
        q_next  = inc_sum[WIDTH-1:0];
        co_next = inc_sum[WIDTH];
      end
      default: begin
        q_next  = q_reg;
        co_next = co_reg;
      end
    endcase
  end

  // State update: reset dominates, en=0 freezes q, co and zero together.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg    <= RESET_VALUE;
      co_reg   <= 1'b0;
      zero_reg <= (RESET_VALUE == {WIDTH{1'b0}});
    end else if (bus.en) begin
      q_reg    <= q_next;
      co_reg   <= co_next;
      zero_reg <= (q_next == {WIDTH{1'b0}});
    end
  end

  assign bus.q    = q_reg;
  assign bus.co   = co_reg;
  assign bus.zero = zero_reg;

endmodule
`default_nettype wire

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parametrised successor to the fixed 32-bit D register: a WIDTH-bit clocked register with synchronous reset, enable, and an operation select.
- Operations: hold, parallel load, logical/arithmetic shift, rotate, and increment.
- Provides a registered shift/carry-out bit and a registered zero flag.
- Used as a general datapath register (accumulator, shifter, counter) in later lab datapaths.

Parameters:
- WIDTH, 32, data width in bits (legal range 2 to 64).
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge only.
- reset  input  1  synchronous, active-high reset.
- en  input  1  operation enable; 0 = hold all state.
- op  input  3  operation select (encoding below).
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input bit for logical shifts.
- q  output  WIDTH  registered value.
- co  output  1  registered shift-out / carry-out bit.
- zero  output  1  registered flag: 1 when the q written at the same edge equals 0.

Behaviour:
- All outputs are registers. No combinational path from any input to any output.
- d, op, sin and en are sampled only at the rising edge of clk. Changes between edges have no effect.
- Reset has priority over everything. At a rising edge with reset=1, regardless of en/op:
  - q = RESET_VALUE
  - co = 0
  - zero = (RESET_VALUE == 0)
- en=0 and reset=0: q, co and zero all hold.
- en=1 and reset=0: the op encoding below applies. Latency is 1 cycle: the result is visible on q after the edge.
- op encoding (q' = next q, co' = next co):
  - 000 hold: q' = q, co' = co.
  - 001 load: q' = d, co' = 0.
  - 010 shl: q' = {q[WIDTH-2:0], sin}, co' = q[WIDTH-1].
  - 011 shr (logical): q' = {sin, q[WIDTH-1:1]}, co' = q[0].
  - 100 asr: q' = {q[WIDTH-1], q[WIDTH-1:1]}, co' = q[0].
  - 101 rol: q' = {q[WIDTH-2:0], q[WIDTH-1]}, co' = q[WIDTH-1].
  - 110 ror: q' = {q[0], q[WIDTH-1:1]}, co' = q[0].
  - 111 inc: {co', q'} = q + 1, computed at WIDTH+1 bits. Wrap-around: all-ones goes to 0 with co' = 1. Otherwise co' = 0.
- zero is updated whenever q is updated, including hold with en=1: zero' = (q' == 0). It holds when en=0.
- Mid-operation reset: a reset asserted during any shift/inc sequence returns the block to reset state at that edge. The next enabled edge after reset deasserts operates on RESET_VALUE.
- Unknown/X op with en=1: the design treats it as hold. No latch inference. A case default is required.
- Width rules:
  - No truncation warnings allowed.
  - The inc adder is WIDTH+1 bits.
  - Shift/rotate amount is exactly 1 bit per enabled cycle.

Test Plan:
- Run with the default WIDTH=32 and STEP=20 ns clock.
- Test 1 (reset): reset=1 for 1 edge with en=1, op=001, d=32'h12345678 → q=32'h00000000, co=0, zero=1; load ignored.
- Test 2 (load and sampling):
  - en=1, op=001, d=32'h98765432 at the edge → q=32'h98765432, zero=0.
  - d then changes to 32'hffeeddcc mid-cycle with en=0 → q stays 32'h98765432.
- Test 3 (shl/shr): starting from q=32'h80000001:
  - op=010, sin=1 → q=32'h00000003, co=1.
  - Then op=011, sin=0 → q=32'h00000001, co=1.
- Test 4 (asr/rotate): starting from q=32'h80000000:
  - op=100 → q=32'hC0000000, co=0.
  - Then load 32'h00000001 and op=110 → q=32'h80000000, co=1.
  - Then op=101 → q=32'h00000001, co=1.
- Test 5 (inc wrap): load 32'hFFFFFFFE, then op=111 for 2 edges:
  - After edge 1: q=32'hFFFFFFFF, co=0, zero=0.
  - After edge 2: q=32'h00000000, co=1, zero=1.
- Test 6 (reset mid-sequence and parameter): during repeated op=111 from 32'h00000005, assert reset for one edge → q=0, co=0. The next inc gives q=1. Repeat with WIDTH=8, RESET_VALUE=8'hA5:
  - reset → q=8'hA5, zero=0.
  - op=101 → q=8'h4B, co=1.
